// File: rtl/fft_reorder.sv
// Ping-pong reorder buffer: takes a bit-reversed FFT frame, replays it in natural bin order.
// Optional macro FFT_REORDER_FFTSHIFT_EN swaps output halves (DC-centred order).
module fft_reorder #(
    parameter int N     = 128,
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             di_en,
    input  logic [WIDTH-1:0] di_re,
    input  logic [WIDTH-1:0] di_im,
    output logic             do_en,
    output logic [WIDTH-1:0] do_re,
    output logic [WIDTH-1:0] do_im,
    output logic             busy
);

    localparam int LOG_N = $clog2(N);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        READ = 1'b1
    } state_t;

    function automatic logic [LOG_N-1:0] bitrev(input logic [LOG_N-1:0] v);
        logic [LOG_N-1:0] r;
        r = '0;
        for (int i = 0; i < LOG_N; i++) begin
            r[i] = v[LOG_N-1-i];
        end
        return r;
    endfunction

    logic [2*WIDTH-1:0] mem_r [0:2*N-1];
    logic [2*WIDTH-1:0] rd_data_r;

    logic [LOG_N-1:0] wr_cnt_r;
    logic             wr_bank_r;
    logic [LOG_N-1:0] rd_cnt_r;
    logic [LOG_N-1:0] rd_cnt_nxt_s;
    logic             rd_bank_r;
    logic             rd_bank_nxt_s;
    state_t           state_r;
    state_t           state_nxt_s;
    logic             en_s1_r;
    logic             frame_close_s;
    logic [LOG_N-1:0] rd_idx_s;
    logic [LOG_N:0]   rd_addr_s;

    assign frame_close_s = di_en && (wr_cnt_r == LOG_N'(N - 1));

`ifdef FFT_REORDER_FFTSHIFT_EN
    assign rd_idx_s = bitrev(rd_cnt_r) ^ LOG_N'(1);
`else
    assign rd_idx_s = bitrev(rd_cnt_r);
`endif

    assign rd_addr_s = {rd_bank_r, rd_idx_s};

    // Sample RAM: write port from the input side, registered read port for the replay side.
    always_ff @(posedge clk) begin
        if (di_en && !rst) begin
            mem_r[{wr_bank_r, wr_cnt_r}] <= {di_re, di_im};
        end
        rd_data_r <= mem_r[rd_addr_s];
    end

    // Write-side counter and bank pointer; bank flips when a frame completes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_cnt_r  <= '0;
            wr_bank_r <= 1'b0;
        end else if (di_en) begin
            wr_cnt_r <= wr_cnt_r + LOG_N'(1);
            if (frame_close_s) begin
                wr_bank_r <= ~wr_bank_r;
            end
        end
    end

    // Read FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= IDLE;
            rd_cnt_r  <= '0;
            rd_bank_r <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            rd_cnt_r  <= rd_cnt_nxt_s;
            rd_bank_r <= rd_bank_nxt_s;
        end
    end

    // Read FSM next state: a closing frame always restarts the read at bin 0 on the just-filled bank.
    always_comb begin
        state_nxt_s   = state_r;
        rd_cnt_nxt_s  = rd_cnt_r;
        rd_bank_nxt_s = rd_bank_r;
        case (state_r)
            IDLE: begin
                if (frame_close_s) begin
                    state_nxt_s   = READ;
                    rd_cnt_nxt_s  = '0;
                    rd_bank_nxt_s = wr_bank_r;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            READ: begin
                if (frame_close_s) begin
                    state_nxt_s   = READ;
                    rd_cnt_nxt_s  = '0;
                    rd_bank_nxt_s = wr_bank_r;
                end else if (rd_cnt_r == LOG_N'(N - 1)) begin
                    state_nxt_s  = IDLE;
                    rd_cnt_nxt_s = '0;
                end else begin
                    rd_cnt_nxt_s = rd_cnt_r + LOG_N'(1);
                end
            end
            default: begin
                state_nxt_s   = IDLE;
                rd_cnt_nxt_s  = '0;
                rd_bank_nxt_s = 1'b0;
            end
        endcase
    end

    // Output pipeline; busy is precomputed so it lines up with the state and valid stages.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en_s1_r <= 1'b0;
            do_en   <= 1'b0;
            do_re   <= '0;
            do_im   <= '0;
            busy    <= 1'b0;
        end else begin
            en_s1_r <= (state_r == READ);
            do_en   <= en_s1_r;
            busy    <= (state_nxt_s == READ) || (state_r == READ) || en_s1_r;
            if (en_s1_r) begin
                {do_re, do_im} <= rd_data_r;
            end
        end
    end

endmodule

// File: tb/tb_fft_reorder.sv
// Scoreboard bench for fft_reorder: an N=8 instance for directed scenarios and an N=128 instance for streaming.
module tb_fft_reorder;

`ifdef FFT_REORDER_FFTSHIFT_EN
    localparam int SH = 1;
`else
    localparam int SH = 0;
`endif

    logic        clk;
    logic        rst;
    logic        di_en8,  do_en8,  busy8;
    logic [15:0] di_re8,  di_im8,  do_re8,  do_im8;
    logic        di_en128, do_en128, busy128;
    logic [15:0] di_re128, di_im128, do_re128, do_im128;

    logic [31:0] q8   [$];
    logic [31:0] q128 [$];
    logic [31:0] e8, e128;
    int pass_cnt = 0;
    int total_cnt = 0;

    fft_reorder #(.N(8), .WIDTH(16)) u8 (
        .clk(clk), .rst(rst), .di_en(di_en8), .di_re(di_re8), .di_im(di_im8),
        .do_en(do_en8), .do_re(do_re8), .do_im(do_im8), .busy(busy8)
    );

    fft_reorder #(.N(128), .WIDTH(16)) u128 (
        .clk(clk), .rst(rst), .di_en(di_en128), .di_re(di_re128), .di_im(di_im128),
        .do_en(do_en128), .do_re(do_re128), .do_im(do_im128), .busy(busy128)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic int brev(input int v, input int bits);
        int r;
        r = 0;
        for (int i = 0; i < bits; i++) begin
            if (((v >> i) & 1) != 0) r = r | (1 << (bits - 1 - i));
        end
        return r;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitors: pop one expected sample per valid output.
    always @(negedge clk) begin
        if (do_en8) begin
            chk("sb8_has_exp", (q8.size() > 0), 1'b1);
            if (q8.size() > 0) begin
                e8 = q8.pop_front();
                chk("data8", {do_re8, do_im8}, e8);
            end
        end
    end

    always @(negedge clk) begin
        if (do_en128) begin
            chk("sb128_has_exp", (q128.size() > 0), 1'b1);
            if (q128.size() > 0) begin
                e128 = q128.pop_front();
                chk("data128", {do_re128, do_im128}, e128);
            end
        end
    end

    // Sample at position p carries value base+p; natural bin k is stored at position brev(k).
    task automatic send8(input int base, input int gap);
        for (int k = 0; k < 8; k++) begin
            int idx;
            idx = brev(k, 3) ^ SH;
            q8.push_back({16'(base + idx), 16'(-(base + idx))});
        end
        for (int p = 0; p < 8; p++) begin
            di_en8 = 1'b1;
            di_re8 = 16'(base + p);
            di_im8 = 16'(-(base + p));
            tick();
            if (gap > 0 && p < 7) begin
                di_en8 = 1'b0;
                repeat (gap) tick();
            end
        end
        di_en8 = 1'b0;
    endtask

    task automatic lat8(input string nm, input int expc);
        int c;
        c = 0;
        while (!do_en8 && c < 40) begin
            tick();
            c++;
        end
        chk(nm, c, expc);
    endtask

    task automatic burst8(input string nm, input int expn);
        int n;
        n = 0;
        while (do_en8 && n < 200) begin
            n++;
            tick();
        end
        chk(nm, n, expn);
        chk({nm, "_busy_after"}, busy8, 1'b0);
    endtask

    task automatic quiet8(input string nm, input int cycles);
        int n;
        n = 0;
        for (int i = 0; i < cycles; i++) begin
            if (do_en8) n++;
            tick();
        end
        chk(nm, n, 0);
    endtask

    initial begin
        rst = 1'b1;
        di_en8 = 1'b0; di_re8 = '0; di_im8 = '0;
        di_en128 = 1'b0; di_re128 = '0; di_im128 = '0;
        repeat (2) tick();
        chk("rst_do_en", do_en8, 1'b0);
        chk("rst_do_re", do_re8, 16'd0);
        chk("rst_do_im", do_im8, 16'd0);
        chk("rst_busy", busy8, 1'b0);
        chk("rst_do_en128", do_en128, 1'b0);
        rst = 1'b0;
        tick();

        // Contiguous frame: values 0..7 / -(0..7).
        send8(0, 0);
        chk("busy_during_read", busy8, 1'b1);
        lat8("lat_contig", 2);
        burst8("burst_contig", 8);

        // Gapped input 1,0,0,1,...: same order, same latency from the 8th accepted sample.
        send8(0, 2);
        lat8("lat_gapped", 2);
        burst8("burst_gapped", 8);

        // Two back-to-back frames stream as one unbroken burst.
        fork
            begin
                send8(16, 0);
                send8(32, 0);
            end
            begin
                int c;
                c = 0;
                while (!do_en8 && c < 60) begin
                    tick();
                    c++;
                end
                chk("b2b_start", do_en8, 1'b1);
                burst8("burst_b2b", 16);
            end
        join

        // Partial frame then reset, with di_en held high across reset edges.
        for (int p = 0; p < 5; p++) begin
            di_en8 = 1'b1;
            di_re8 = 16'(200 + p);
            di_im8 = 16'(300 + p);
            tick();
        end
        rst = 1'b1;
        di_re8 = 16'hdead;
        di_im8 = 16'hbeef;
        repeat (2) tick();
        rst = 1'b0;
        di_en8 = 1'b0;
        quiet8("partial_no_out", 12);
        send8(80, 0);
        lat8("lat_after_partial", 2);
        burst8("burst_after_partial", 8);

        // Reset in the middle of the output burst.
        send8(48, 0);
        lat8("lat_pre_midrst", 2);
        repeat (3) tick();
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_do_en", do_en8, 1'b0);
        chk("midrst_do_re", do_re8, 16'd0);
        chk("midrst_do_im", do_im8, 16'd0);
        chk("midrst_busy", busy8, 1'b0);
        q8.delete();
        tick();
        rst = 1'b0;
        quiet8("midrst_no_out", 20);
        send8(64, 0);
        lat8("lat_after_midrst", 2);
        burst8("burst_after_midrst", 8);

        // N=128: three contiguous frames give 384 contiguous outputs with busy held high.
        fork
            begin
                for (int f = 0; f < 3; f++) begin
                    for (int k = 0; k < 128; k++) begin
                        int idx;
                        idx = brev(k, 7) ^ SH;
                        q128.push_back({16'(f * 1000 + idx * 3 + 7), ~16'(f * 1000 + idx * 3 + 7)});
                    end
                    for (int p = 0; p < 128; p++) begin
                        di_en128 = 1'b1;
                        di_re128 = 16'(f * 1000 + p * 3 + 7);
                        di_im128 = ~16'(f * 1000 + p * 3 + 7);
                        tick();
                    end
                end
                di_en128 = 1'b0;
            end
            begin
                int c;
                int n;
                int blo;
                chk("busy128_before", busy128, 1'b0);
                c = 0;
                while (!do_en128 && c < 600) begin
                    tick();
                    c++;
                end
                chk("stream128_start", do_en128, 1'b1);
                n = 0;
                blo = 0;
                while (do_en128 && n < 1000) begin
                    n++;
                    if (!busy128) blo++;
                    tick();
                end
                chk("burst128", n, 384);
                chk("busy128_low_in_burst", blo, 0);
                chk("busy128_after", busy128, 1'b0);
            end
        join

        repeat (4) tick();
        chk("q8_drained", q8.size(), 0);
        chk("q128_drained", q128.size(), 0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
